// File: rtl/ipf_lcu_feeder.sv
// Upstream feeder of the image processing filter: reads a 128x128 image and per-LCU
// parameters, and streams pixels in LCU-raster order through a small output FIFO.
module ipf_lcu_feeder #(
   parameter int IMG_W      = 128,
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  lcu_size,
   output logic        img_rd,
   output logic [13:0] img_addr,
   input  logic [7:0]  img_data,
   output logic        par_rd,
   output logic [5:0]  par_addr,
   input  logic [23:0] par_data,
   output logic        in_en,
   output logic [7:0]  din,
   output logic [1:0]  ipf_type,
   output logic [4:0]  ipf_band_pos,
   output logic        ipf_wo_class,
   output logic [15:0] ipf_offset,
   output logic [2:0]  lcu_x,
   output logic [2:0]  lcu_y,
   input  logic        busy,
   output logic        done
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   typedef struct packed {
      logic [7:0]  pix;
      logic [23:0] par;
      logic [2:0]  x;
      logic [2:0]  y;
   } entry_t;

   state_t state, state_nx;
   logic [1:0]  sz;
   logic [5:0]  col, row, smax;
   logic [2:0]  lx, ly, nmax;
   logic [6:0]  ypix, xpix;
   logic        issue, pop, credit, last_pix;
   logic        rd_pend, par_pend;
   logic [2:0]  lx_d, ly_d;
   logic [23:0] par_reg;
   entry_t      mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;

   always_comb begin
      smax = 6'd63;
      nmax = 3'(IMG_W / 64 - 1);
      ypix = {ly[0], row[5:0]};
      xpix = {lx[0], col[5:0]};
      par_addr = {4'd0, ly[0], lx[0]};
      case (sz)
         2'd0: begin
            smax = 6'd15;
            nmax = 3'(IMG_W / 16 - 1);
            ypix = {ly[2:0], row[3:0]};
            xpix = {lx[2:0], col[3:0]};
            par_addr = {ly[2:0], lx[2:0]};
         end
         2'd1: begin
            smax = 6'd31;
            nmax = 3'(IMG_W / 32 - 1);
            ypix = {ly[1:0], row[4:0]};
            xpix = {lx[1:0], col[4:0]};
            par_addr = {2'd0, ly[1:0], lx[1:0]};
         end
         default: ;
      endcase
   end

   // A read may only be issued if its data is guaranteed a FIFO slot when it returns.
   assign pop      = (count != '0) && !busy;
   assign credit   = (int'(count) + int'(rd_pend) - int'(pop)) < FIFO_DEPTH;
   assign issue    = (state == RUN) && credit;
   assign last_pix = (col == smax) && (row == smax) && (lx == nmax) && (ly == nmax);

   assign img_rd   = issue;
   assign img_addr = {ypix, xpix};
   assign par_rd   = issue && (col == 6'd0) && (row == 6'd0);

   always_comb begin
      state_nx = state;
      done     = 1'b0;
      case (state)
         IDLE:  if (start) state_nx = RUN;
         RUN:   if (issue && last_pix) state_nx = DRAIN;
         DRAIN: if ((count == '0) && !rd_pend) begin
                   done     = 1'b1;
                   state_nx = IDLE;
                end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Pixel counters wrap col, then row, then lcu_x, then lcu_y.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sz  <= 2'd0;
         col <= 6'd0;
         row <= 6'd0;
         lx  <= 3'd0;
         ly  <= 3'd0;
      end else if (state == IDLE && start) begin
         sz  <= (lcu_size == 2'd3) ? 2'd2 : lcu_size;
         col <= 6'd0;
         row <= 6'd0;
         lx  <= 3'd0;
         ly  <= 3'd0;
      end else if (issue) begin
         if (col != smax) col <= col + 6'd1;
         else begin
            col <= 6'd0;
            if (row != smax) row <= row + 6'd1;
            else begin
               row <= 6'd0;
               if (lx != nmax) lx <= lx + 3'd1;
               else begin
                  lx <= 3'd0;
                  ly <= (ly != nmax) ? ly + 3'd1 : 3'd0;
               end
            end
         end
      end
   end

   // Returned parameters are bypassed into the first pixel of the LCU as well as registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_pend  <= 1'b0;
         par_pend <= 1'b0;
         lx_d     <= 3'd0;
         ly_d     <= 3'd0;
         par_reg  <= 24'd0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         rd_pend  <= issue;
         par_pend <= par_rd;
         if (issue) begin
            lx_d <= lx;
            ly_d <= ly;
         end
         if (par_pend) par_reg <= par_data;
         if (rd_pend) begin
            mem[wr_ptr] <= {img_data, par_pend ? par_data : par_reg, lx_d, ly_d};
            wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({rd_pend, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign in_en = (count != '0);
   assign {din, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset, lcu_x, lcu_y} = mem[rd_ptr];

endmodule

// File: tb/tb_ipf_lcu_feeder.sv
// Randomized bench for ipf_lcu_feeder: memory models plus an arithmetic LCU-raster
// reference for addresses, beats, parameter fetches and frame timing.
module tb_ipf_lcu_feeder;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  lcu_size;
   logic        img_rd;
   logic [13:0] img_addr;
   logic [7:0]  img_data;
   logic        par_rd;
   logic [5:0]  par_addr;
   logic [23:0] par_data;
   logic        in_en;
   logic [7:0]  din;
   logic [1:0]  ipf_type;
   logic [4:0]  ipf_band_pos;
   logic        ipf_wo_class;
   logic [15:0] ipf_offset;
   logic [2:0]  lcu_x;
   logic [2:0]  lcu_y;
   logic        busy;
   logic        done;

   logic [7:0]  imgMem [16384];
   logic [23:0] parMem [64];
   int          checks = 0;
   int          errors = 0;

   ipf_lcu_feeder #(.IMG_W(128), .FIFO_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .start(start), .lcu_size(lcu_size),
      .img_rd(img_rd), .img_addr(img_addr), .img_data(img_data),
      .par_rd(par_rd), .par_addr(par_addr), .par_data(par_data),
      .in_en(in_en), .din(din), .ipf_type(ipf_type), .ipf_band_pos(ipf_band_pos),
      .ipf_wo_class(ipf_wo_class), .ipf_offset(ipf_offset),
      .lcu_x(lcu_x), .lcu_y(lcu_y), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Both memories return data the cycle after the read strobe.
   always @(posedge clk) begin
      if (img_rd) img_data <= imgMem[img_addr];
      if (par_rd) par_data <= parMem[par_addr];
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int lcuSide(input int s);
      return 16 << s;
   endfunction

   function automatic int expAddr(input int idx, input int s);
      int side, n, lcu, p;
      side = lcuSide(s);
      n    = 128 / side;
      lcu  = idx / (side * side);
      p    = idx % (side * side);
      return ((lcu / n) * side + p / side) * 128 + (lcu % n) * side + p % side;
   endfunction

   function automatic logic [37:0] expBeat(input int idx, input int s);
      int side, n, lcu;
      logic [2:0] ex, ey;
      side = lcuSide(s);
      n    = 128 / side;
      lcu  = idx / (side * side);
      ex   = 3'(lcu % n);
      ey   = 3'(lcu / n);
      return {imgMem[expAddr(idx, s)], parMem[lcu], ex, ey};
   endfunction

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_in_en"}, in_en, 0);
      checkOutput({tag, "_din"}, din, 0);
      checkOutput({tag, "_type"}, ipf_type, 0);
      checkOutput({tag, "_band"}, ipf_band_pos, 0);
      checkOutput({tag, "_wo"}, ipf_wo_class, 0);
      checkOutput({tag, "_offset"}, ipf_offset, 0);
      checkOutput({tag, "_lcu_x"}, lcu_x, 0);
      checkOutput({tag, "_lcu_y"}, lcu_y, 0);
      checkOutput({tag, "_img_rd"}, img_rd, 0);
      checkOutput({tag, "_img_addr"}, img_addr, 0);
      checkOutput({tag, "_par_rd"}, par_rd, 0);
      checkOutput({tag, "_par_addr"}, par_addr, 0);
      checkOutput({tag, "_done"}, done, 0);
   endtask

   // One frame; resetAt > 0 aborts it with reset, midStartAt > 0 pokes start/lcu_size mid-frame.
   task automatic applyStimulus(input logic [1:0] sz, input int busyPct, input int midStartAt,
                                input int resetAt, input bit startAtDone);
      int  s, ppl, nLcu, beatIdx, readIdx, stalls, parCount;
      bit  finished, aborted;
      s        = (sz == 2'd3) ? 2 : int'(sz);
      ppl      = lcuSide(s) * lcuSide(s);
      nLcu     = 16384 / ppl;
      beatIdx  = 0;
      readIdx  = 0;
      stalls   = 0;
      parCount = 0;
      finished = 0;
      aborted  = 0;
      @(posedge clk); #1;
      start    = 1'b1;
      lcu_size = sz;
      busy     = 1'b0;
      for (int c = 1; c <= 40000 && !finished; c++) begin
         @(posedge clk); #1;
         start = (c == midStartAt) || (startAtDone && c == 16387);
         if (c == midStartAt) lcu_size = 2'd1;
         busy = (busyPct > 0) && ($urandom_range(99) < busyPct);
         if (c == resetAt) begin
            busy  = 1'b1;
            reset = 1'b0;
            #1;
            checkResetOutputs("midreset");
            finished = 1;
            aborted  = 1;
         end else begin
            @(negedge clk);
            if (c == 1) checkOutput("first_img_rd", img_rd, 1);
            if (c == 2) checkOutput("in_en_c2", in_en, 0);
            if (c == 3) checkOutput("in_en_c3", in_en, 1);
            if (img_rd || par_rd)
               checkOutput("par_rd", par_rd, img_rd && (readIdx % ppl == 0));
            if (par_rd) begin
               parCount++;
               checkOutput("par_addr", par_addr, readIdx / ppl);
            end
            if (img_rd) begin
               checkOutput("img_addr", img_addr, expAddr(readIdx, s));
               readIdx++;
            end
            if (in_en) begin
               if (beatIdx >= 16384) checkOutput("extra_beat", 1, 0);
               else checkOutput("beat", {din, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
                                         lcu_x, lcu_y}, expBeat(beatIdx, s));
               if (busy) stalls++;
               else      beatIdx++;
            end
            if (done) begin
               checkOutput("done_cycle", c, 16387 + stalls);
               checkOutput("beat_count", beatIdx, 16384);
               checkOutput("par_rd_count", parCount, nLcu);
               finished = 1;
            end
         end
      end
      if (!finished) checkOutput("timeout", 0, 1);
      if (!aborted) begin
         for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            busy  = 1'b0;
            @(negedge clk);
            checkOutput("idle_img_rd", img_rd, 0);
            checkOutput("idle_in_en", in_en, 0);
            checkOutput("idle_done", done, 0);
         end
      end
   endtask

   initial begin
      reset    = 1'b0;
      start    = 1'b0;
      busy     = 1'b0;
      lcu_size = 2'd0;
      for (int i = 0; i < 16384; i++) imgMem[i] = 8'($urandom);
      for (int k = 0; k < 64; k++) parMem[k] = 24'((k + 1) * 24'h010101);
      repeat (3) @(negedge clk);
      checkResetOutputs("reset");
      reset = 1'b1;

      $display("[TB] frame: lcu_size=2, no stall");
      applyStimulus(2'd2, 0, -1, -1, 1'b0);

      $display("[TB] frame: lcu_size=0, 50%% busy, start and lcu_size poked mid-frame");
      applyStimulus(2'd0, 50, 500, -1, 1'b0);

      $display("[TB] frame: lcu_size=0, reset at cycle 1000 while stalled");
      applyStimulus(2'd0, 0, -1, 1000, 1'b0);
      repeat (2) @(negedge clk);
      checkResetOutputs("held_reset");
      reset = 1'b1;
      busy  = 1'b0;

      $display("[TB] frame: lcu_size=3 after reset, start held in done cycle");
      applyStimulus(2'd3, 0, -1, -1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
